sme_unmask_seq: RTL and testbench

Sequential share recombiner for the SME masked datapath: it accepts an N-bit value held as D Boolean shares and emits the unmasked plaintext. It is the consuming end of the share encoding that the masked gadgets (DOM AND, etc.) produce. Shares are refreshed once, then folded into the accumulator one share per cycle, so no single cycle combines every share. It sits at the SME-to-GPR writeback boundary, behind a valid/ready handshake on each side.

---
 rtl/sme_unmask_seq_if.sv | 23 ++
 rtl/sme_unmask_seq.sv | 80 ++++++++
 tb/tb_sme_unmask_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sme_unmask_seq_if.sv
// rtl/sme_unmask_seq_if.sv - share-in / plaintext-out handshake bundle for sme_unmask_seq
interface sme_unmask_seq_if #(
  parameter int D = 3,
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N*D-1:0] in_shares;
  logic [N-1:0]   rng;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;

  modport master (
    output in_valid, in_shares, rng, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_shares, rng, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sme_unmask_seq.sv
// rtl/sme_unmask_seq.sv - sequential Boolean share recombiner
// Refreshes once, then folds one share per cycle so no cycle combines all shares.
module sme_unmask_seq #(
  parameter int D = 3,
  parameter int N = 32
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               flush,
  sme_unmask_seq_if.slave    bus,
  output logic               busy
);
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sh_q [D];
  logic [N-1:0]  sh_d [D];
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge g_clk) begin
    if (g_reset || flush) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      for (int s = 0; s < D; s++) sh_q[s] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      for (int s = 0; s < D; s++) sh_q[s] <= sh_d[s];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    for (int s = 0; s < D; s++) sh_d[s] = sh_q[s];

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int s = 0; s < D; s++) sh_d[s] = bus.in_shares[s*N +: N];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Same mask on two shares leaves the recombined value unchanged.
        sh_d[0]   = sh_q[0] ^ bus.rng;
        sh_d[D-1] = sh_q[D-1] ^ bus.rng;
        state_d   = FOLD;
      end
      FOLD: begin
        acc_d = acc_q ^ sh_q[0];
        for (int s = 0; s < D - 1; s++) sh_d[s] = sh_q[s+1];
        sh_d[D-1] = '0;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(D - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q == DONE) ? acc_q : '0;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_sme_unmask_seq.sv
// tb/tb_sme_unmask_seq.sv - self-checking bench for sme_unmask_seq (D=3 and D=2 builds)
module tb_sme_unmask_seq;
  logic g_clk = 1'b0;
  logic g_reset;
  logic flush;
  logic busy3, busy2;
  int   checks = 0;
  int   errors = 0;

  always #5 g_clk = ~g_clk;

  sme_unmask_seq_if #(.D(3), .N(32)) b3 ();
  sme_unmask_seq_if #(.D(2), .N(32)) b2 ();

  sme_unmask_seq #(.D(3), .N(32)) dut3 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .bus(b3), .busy(busy3)
  );
  sme_unmask_seq #(.D(2), .N(32)) dut2 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .bus(b2), .busy(busy2)
  );

  typedef struct {
    int          w;
    logic [255:0] sh;
    logic [31:0] r;
    logic [31:0] exp;
    int          hold;
    bit          pulse;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic ov(input int w);
    return (w == 3) ? b3.out_valid : b2.out_valid;
  endfunction
  function automatic logic ir(input int w);
    return (w == 3) ? b3.in_ready : b2.in_ready;
  endfunction
  function automatic logic [31:0] od(input int w);
    return (w == 3) ? b3.out_data : b2.out_data;
  endfunction
  function automatic logic bz(input int w);
    return (w == 3) ? busy3 : busy2;
  endfunction

  // Reference: plaintext is simply the XOR of the first w shares.
  function automatic logic [31:0] model(input int w, input logic [255:0] sh);
    logic [31:0] x = '0;
    for (int s = 0; s < w; s++) x ^= sh[s*32 +: 32];
    return x;
  endfunction

  task automatic drive(input int w, input logic v, input logic [255:0] sh, input logic [31:0] r);
    if (w == 3) begin
      b3.in_valid = v; b3.in_shares = sh[95:0]; b3.rng = r;
    end else begin
      b2.in_valid = v; b2.in_shares = sh[63:0]; b2.rng = r;
    end
  endtask

  task automatic set_ordy(input int w, input logic v);
    if (w == 3) b3.out_ready = v; else b2.out_ready = v;
  endtask

  task automatic check_idle(input int w, input string nm);
    chk({nm, "_in_ready"}, 64'(ir(w)), 64'd1);
    chk({nm, "_out_valid"}, 64'(ov(w)), 64'd0);
    chk({nm, "_out_data"}, 64'(od(w)), 64'd0);
    chk({nm, "_busy"}, 64'(bz(w)), 64'd0);
  endtask

  // Accept at negedge cycle 0; result expected valid at cycle w+2.
  task automatic txn(input int w, input logic [255:0] sh, input logic [31:0] r,
                     input logic [31:0] exp, input int hold, input bit pulse, input string nm);
    int lat;
    @(negedge g_clk);
    chk({nm, "_accept_ready"}, 64'(ir(w)), 64'd1);
    drive(w, 1'b1, sh, r);
    set_ordy(w, hold == 0);
    @(negedge g_clk);
    drive(w, 1'b0, 256'h0, r);
    lat = 1;
    while (!ov(w) && lat < 20) begin
      chk({nm, "_busy_mid"}, 64'(bz(w)), 64'd1);
      @(negedge g_clk);
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(w + 2));
    chk({nm, "_data"}, 64'(od(w)), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 2) drive(w, 1'b1, ~sh, r);
      if (pulse && i == 3) drive(w, 1'b0, 256'h0, r);
      @(negedge g_clk);
      chk({nm, "_hold_data"}, 64'(od(w)), 64'(exp));
      chk({nm, "_hold_in_ready"}, 64'(ir(w)), 64'd0);
    end
    drive(w, 1'b0, 256'h0, r);
    set_ordy(w, 1'b1);
    @(negedge g_clk);
    check_idle(w, {nm, "_after"});
  endtask

  initial begin
    logic [255:0] rsh;
    logic [31:0]  rr;
    int           ww;

    tbl[0] = '{3, 256'({32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5}), 32'h0,        32'hB89EFCD2, 0, 1'b0};
    tbl[1] = '{3, 256'({32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5}), 32'hDEADBEEF, 32'hB89EFCD2, 0, 1'b0};
    tbl[2] = '{3, 256'({32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5}), 32'hFFFFFFFF, 32'hB89EFCD2, 0, 1'b0};
    tbl[3] = '{3, 256'({32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5}), 32'h13572468, 32'hB89EFCD2, 7, 1'b1};
    tbl[4] = '{2, 256'({32'h00FFFF00, 32'hFFFF0000}),               32'h13579BDF, 32'hFF00FF00, 0, 1'b0};

    g_reset = 1'b1;
    flush   = 1'b0;
    drive(3, 1'b0, 256'h0, 32'h0);
    drive(2, 1'b0, 256'h0, 32'h0);
    set_ordy(3, 1'b1);
    set_ordy(2, 1'b1);
    repeat (3) @(negedge g_clk);
    g_reset = 1'b0;
    check_idle(3, "reset3");
    check_idle(2, "reset2");

    foreach (tbl[i])
      txn(tbl[i].w, tbl[i].sh, tbl[i].r, tbl[i].exp, tbl[i].hold, tbl[i].pulse,
          $sformatf("vec%0d", i));

    // Flush in the second FOLD cycle (cycle 3 after acceptance).
    @(negedge g_clk);
    drive(3, 1'b1, 256'({32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5}), 32'h5A5A5A5A);
    @(negedge g_clk);
    drive(3, 1'b0, 256'h0, 32'h5A5A5A5A);
    @(negedge g_clk);
    @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check_idle(3, "flush");
    txn(3, 256'({32'h4, 32'h2, 32'h1}), 32'h0, 32'h7, 0, 1'b0, "post_flush");

    // Reset while holding in DONE.
    @(negedge g_clk);
    drive(3, 1'b1, 256'({32'h4, 32'h2, 32'h1}), 32'h0);
    set_ordy(3, 1'b0);
    @(negedge g_clk);
    drive(3, 1'b0, 256'h0, 32'h0);
    repeat (4) @(negedge g_clk);
    chk("reset_pre_done", 64'(ov(3)), 64'd1);
    g_reset = 1'b1;
    @(negedge g_clk);
    check_idle(3, "reset_done");
    // Reset together with in_valid in IDLE must not capture.
    drive(3, 1'b1, 256'({32'h4, 32'h2, 32'h1}), 32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;
    drive(3, 1'b0, 256'h0, 32'h0);
    set_ordy(3, 1'b1);
    check_idle(3, "reset_valid");
    @(negedge g_clk);
    check_idle(3, "reset_valid_next");

    for (int k = 0; k < 24; k++) begin
      ww = (k % 3 == 2) ? 2 : 3;
      rsh = '0;
      for (int s = 0; s < ww; s++) rsh[s*32 +: 32] = $urandom;
      rr = $urandom;
      txn(ww, rsh, rr, model(ww, rsh), int'($urandom_range(0, 3)), 1'b0,
          $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
